// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, load results queue in an in-order FIFO.
// Optional macro WB_PENDING_CHECK_EN adds the chk_addr/chk_pending in-flight write lookup.
module wb_write_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
`ifdef WB_PENDING_CHECK_EN
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  output logic                  chk_pending,
`endif
  output logic                  write_En,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [CNT_W-1:0]      pending_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [STV_W-1:0]      starve_cnt;

  logic fifo_nonempty, force_fifo, alu_grant, fifo_grant, push;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  assign fifo_nonempty = (count != '0);
  assign force_fifo    = fifo_nonempty && (starve_cnt == STV_W'(STARVE_LIMIT));
  assign alu_ready     = !force_fifo;
  assign mem_ready     = (count < CNT_W'(FIFO_DEPTH));
  assign push          = mem_valid && mem_ready;
  assign alu_grant     = alu_valid && !force_fifo;
  assign fifo_grant    = !alu_grant && fifo_nonempty;
  assign pending_cnt   = count;

  always_comb begin
    win_addr = alu_addr;
    win_data = alu_data;
    if (fifo_grant) begin
      win_addr = fifo_addr[rd_ptr];
      win_data = fifo_data[rd_ptr];
    end
  end

  // Storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mem_addr;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_grant) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, fifo_grant})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_grant || !fifo_nonempty) begin
      starve_cnt <= '0;
    end else if (alu_grant && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Writes to register 0 are consumed but never enabled; address/data hold like an idle cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      write_En  <= 1'b0;
      writeAddr <= '0;
      data_in   <= '0;
    end else if ((alu_grant || fifo_grant) && (win_addr != '0)) begin
      write_En  <= 1'b1;
      writeAddr <= win_addr;
      data_in   <= win_data;
    end else begin
      write_En  <= 1'b0;
    end
  end

`ifdef WB_PENDING_CHECK_EN
  always_comb begin
    chk_pending = write_En && (writeAddr == chk_addr);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (fifo_addr[rd_ptr + PTR_W'(i)] == chk_addr))
        chk_pending = 1'b1;
    end
    if (chk_addr == '0) chk_pending = 1'b0;
  end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_write_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int FD = 4;
  localparam int SL = 3;
  localparam int CW = $clog2(FD + 1);

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          write_En;
  logic [AW-1:0] writeAddr;
  logic [DW-1:0] data_in;
  logic [CW-1:0] pending_cnt;
`ifdef WB_PENDING_CHECK_EN
  logic [AW-1:0] chk_addr = '0;
  logic          chk_pending;
`endif

  always #5 Clk = ~Clk;

  wb_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef WB_PENDING_CHECK_EN
    .chk_addr(chk_addr), .chk_pending(chk_pending),
`endif
    .write_En(write_En), .writeAddr(writeAddr), .data_in(data_in), .pending_cnt(pending_cnt)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: pending loads as a queue, ALU-win streak count, expected register-file port.
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];
  int            streak;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_data.delete();
    streak   = 0;
    exp_en   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  // Called at a falling edge: drive inputs, check handshakes, advance model, check registered outputs.
  task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    logic starved, alu_win, fifo_win, did_push, had_loads;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    had_loads = (q_addr.size() > 0);
    starved   = had_loads && (streak >= SL);
    check_val("alu_ready", 64'(alu_ready), 64'(!starved));
    check_val("mem_ready", 64'(mem_ready), 64'(q_addr.size() < FD));
`ifdef WB_PENDING_CHECK_EN
    begin
      logic hit;
      hit = exp_en && (exp_addr == chk_addr);
      foreach (q_addr[i]) if (q_addr[i] == chk_addr) hit = 1'b1;
      if (chk_addr == '0) hit = 1'b0;
      check_val("chk_pending", 64'(chk_pending), 64'(hit));
    end
`endif
    alu_win  = av && !starved;
    fifo_win = !alu_win && had_loads;
    did_push = mv && (q_addr.size() < FD);
    wa = aa; wd = ad;
    if (fifo_win) begin
      wa = q_addr.pop_front();
      wd = q_data.pop_front();
    end
    if ((alu_win || fifo_win) && wa != '0) begin
      exp_en = 1'b1; exp_addr = wa; exp_data = wd;
    end else begin
      exp_en = 1'b0;
    end
    if (fifo_win || !had_loads) streak = 0;
    else if (alu_win && streak < SL) streak++;
    if (did_push) begin
      q_addr.push_back(ma);
      q_data.push_back(md);
    end
    @(posedge Clk);
    #1;
    check_val("write_En", 64'(write_En), 64'(exp_en));
    check_val("pending_cnt", 64'(pending_cnt), 64'(q_addr.size()));
    if (exp_en) begin
      check_val("writeAddr", 64'(writeAddr), 64'(exp_addr));
      check_val("data_in", data_in, exp_data);
    end
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_reset_state();
    check_val("rst_write_En", 64'(write_En), 64'd0);
    check_val("rst_writeAddr", 64'(writeAddr), 64'd0);
    check_val("rst_data_in", data_in, 64'd0);
    check_val("rst_pending_cnt", 64'(pending_cnt), 64'd0);
    check_val("rst_mem_ready", 64'(mem_ready), 64'd1);
    check_val("rst_alu_ready", 64'(alu_ready), 64'd1);
  endtask

  initial begin
    int li;
    alu_valid = 0; mem_valid = 0;
    alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0;
    model_reset();
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_reset_state();
    Rst_n = 1'b1;

    // ALU alone
    cycle(1'b1, 5'd5, 64'hDEAD, 1'b0, '0, '0);
    idle(2);

    // FIFO fill under continuous ALU traffic, loads 1..5
    li = 1;
    for (int k = 0; k < 60 && (li <= 5 || q_addr.size() > 0); k++) begin
      logic pushing;
      pushing = (li <= 5) && (q_addr.size() < FD);
      cycle(1'b1, AW'(8 + (k % 16)), DW'(64'h1000 + k), li <= 5, AW'(li), DW'(64'hA000 + li));
      if (pushing) li++;
    end
    check_val("fill_drained", 64'(q_addr.size()), 64'd0);
    idle(2);

    // Register 0 from both sources
    cycle(1'b1, 5'd0, 64'h1111, 1'b1, 5'd0, 64'h2222);
    idle(3);

    // Simultaneous push and pop at occupancy 2
    cycle(1'b1, 5'd3, 64'h33, 1'b1, 5'd9, 64'h99);
    cycle(1'b1, 5'd4, 64'h44, 1'b1, 5'd10, 64'hAA);
    cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd11, 64'hBB);
    check_val("pushpop_cnt", 64'(pending_cnt), 64'd2);
    idle(4);

`ifdef WB_PENDING_CHECK_EN
    chk_addr = 5'd7;
    cycle(1'b1, 5'd2, 64'h2, 1'b1, 5'd7, 64'h77);
    for (int k = 0; k < 5; k++) cycle(1'b1, AW'(12 + k), DW'(k), 1'b0, '0, '0);
    idle(3);
    chk_addr = 5'd0;
    cycle(1'b1, 5'd0, 64'h5, 1'b1, 5'd0, 64'h6);
    idle(2);
`endif

    // Random traffic with one asynchronous reset in the middle
    for (int k = 0; k < 3000; k++) begin
`ifdef WB_PENDING_CHECK_EN
      chk_addr = AW'($urandom_range(0, 7));
`endif
      cycle($urandom_range(0, 99) < 70, AW'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 99) < 50, AW'($urandom_range(0, 7)), {$urandom, $urandom});
      if (k == 1500) begin
        alu_valid = 1'b1; mem_valid = 1'b1;
        #2 Rst_n = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
      end
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
